dual_port_ram_be: RTL and testbench
===================================

Name: dual_port_ram_be

Overview:
Parametrised successor to the team's single-clock 4096x64 simple dual-port RAM: one write port, one read port, configurable width/depth.
- Adds per-byte write enables, selectable read latency (1 or 2 cycles) and a read-valid strobe.
- Adds defined read-during-write collision behaviour, with a collision flag.
- Sits as the generic storage primitive behind packet buffers and descriptor tables.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8
ADDR_W, 12, address width
DEPTH, 4096, number of words; must be <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2 only
RDW_MODE, 1, same-address read-during-write: 0 = return old data, 1 = return new (merged) data

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr  input  1  write enable
wr_add  input  ADDR_W  write address
wr_be  input  DATA_W/8  byte enables; bit i covers in[8i+7:8i]
in  input  DATA_W  write data
rd  input  1  read enable
rd_add  input  ADDR_W  read address
out  output  DATA_W  read data
rd_valid  output  1  out carries the result of a read issued RD_LAT cycles earlier
collision  output  1  the read now presented hit the same in-range address as a concurrent write
range_err  output  1  the read now presented used an address >= DEPTH
parity_err  output  1  parity mismatch on the read now presented (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, rd_valid=0, collision=0, range_err=0, parity_err=0. All read pipeline stages are cleared. Memory contents are NOT reset and survive reset.
- Write: on a clk edge with wr=1 and wr_add<DEPTH, each byte i with wr_be[i]=1 is written; bytes with wr_be[i]=0 keep their old value.
  - wr_be=0 with wr=1 is a legal no-op.
  - wr_add>=DEPTH: the write is dropped silently.
- Read: rd=1 sampled at edge N; the result appears at edge N+RD_LAT-1 registered output, i.e. visible in the cycle after edge N for RD_LAT=1, and one cycle later for RD_LAT=2.
  - rd_valid=1 in exactly the cycle the result is presented.
- rd=0: the matching pipeline slot carries out=0, rd_valid=0, collision=0, range_err=0. This is the zero-when-idle behaviour of the original RAM.
- Out-of-range read (rd_add>=DEPTH): out=0, rd_valid=1, range_err=1.
- Back-to-back reads are fully pipelined, one per cycle, no bubbles, for both latencies.
- Collision: wr=1, rd=1 and wr_add==rd_add<DEPTH in the same cycle.
  - RDW_MODE=0: out = memory contents before the write.
  - RDW_MODE=1: out = per byte, new data where wr_be=1, old data elsewhere.
  - collision=1 aligned with rd_valid. If wr_be=0, collision is still flagged and the data equals the old data.
- A read one or more cycles after a write to the same address always returns the written data (no stale window), for both latencies.
- Reset deasserted mid-stream: the first rd_valid appears RD_LAT cycles after the first post-reset rd.
- Elaboration check: an illegal RD_LAT, DATA_W%8!=0, or DEPTH>2**ADDR_W causes $fatal.

Optional Feature:
Macro DUAL_PORT_RAM_PARITY_EN.
- Defined: one even-parity bit is stored per byte alongside the data, written with that byte.
  - On read, parity is recomputed per byte. parity_err=1, aligned with rd_valid, if any byte mismatches.
  - Bypassed collision bytes (RDW_MODE=1) use freshly computed parity and never flag.
  - Out-of-range reads never flag.
- Not defined: no parity storage; the parity_err port still exists, tied to 0.

Test Plan:
1. Reset, then write 0x0123_4567_89AB_CDEF to addr 5 with wr_be=0xFF; read addr 5 -> out=0x0123456789ABCDEF, rd_valid=1 exactly RD_LAT cycles after rd; repeat with RD_LAT=2.
2. Fill addr 7 with all-ones, then write 0 with wr_be=0x0F -> read returns 0xFFFFFFFF_00000000.
3. Addr 9 holds 0xAAAA...; same cycle write 0x5555... (be=0xFF) and read addr 9 -> RDW_MODE=0: out=0xAAAA..., collision=1; RDW_MODE=1: out=0x5555..., collision=1.
4. Continuous reads of addrs 0..15 with rd held high, one cycle of rd=0 inserted at addr 8 -> 16 valid results in order, one rd_valid gap, out=0 in the gap; assert rst_n=0 mid-burst -> out/rd_valid drop to 0 immediately, and memory data is intact afterwards.
5. DEPTH=3000, ADDR_W=12: write to addr 3500, then read addr 3500 -> out=0, rd_valid=1, range_err=1; addr 2999 reads and writes normally.
6. With DUAL_PORT_RAM_PARITY_EN: write addr 3, flip one data bit of byte 2 via hierarchical force, read -> parity_err=1; without the macro, same stimulus -> parity_err=0.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// rtl/dual_port_ram_be.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency, collision flag; optional parity via DUAL_PORT_RAM_PARITY_EN
module dual_port_ram_be #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_add,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   in,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   rd_add,
    output logic [DATA_W-1:0]   out,
    output logic                rd_valid,
    output logic                collision,
    output logic                range_err,
    output logic                parity_err
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "dual_port_ram_be: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $fatal(1, "dual_port_ram_be: DATA_W must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $fatal(1, "dual_port_ram_be: DEPTH exceeds address space");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              coll;
        logic              rerr;
        logic              perr;
    } rd_stage_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_ok;
    logic              rd_ok;
    logic              rd_oor;
    logic              coll_now;
    logic              perr_now;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_merged;
    logic [NB-1:0]     bypass;
    rd_stage_t         s1_d;
    rd_stage_t         s1_q;
    rd_stage_t         res;

    assign wr_ok    = wr && ({1'b0, wr_add} < DEPTH_L);
    assign rd_ok    = rd && ({1'b0, rd_add} < DEPTH_L);
    assign rd_oor   = rd && !rd_ok;
    assign coll_now = wr_ok && rd_ok && (wr_add == rd_add);

    // Contents are deliberately outside the reset domain so they survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_add][8*i +: 8] <= in[8*i +: 8];
                end
            end
        end
    end

    // Bypassed bytes take the incoming write data when new-data mode is selected.
    always_comb begin
        rd_word   = rd_ok ? mem[rd_add] : '0;
        rd_merged = rd_word;
        bypass    = '0;
        for (int i = 0; i < NB; i++) begin
            bypass[i] = coll_now && (RDW_MODE == 1) && wr_be[i];
            if (bypass[i]) begin
                rd_merged[8*i +: 8] = in[8*i +: 8];
            end
        end
    end

`ifdef DUAL_PORT_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_word;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par_mem[wr_add][i] <= ^in[8*i +: 8];
                end
            end
        end
    end

    // Bypassed bytes come straight from the write bus, so they are never checked.
    always_comb begin
        perr_now = 1'b0;
        par_word = rd_ok ? par_mem[rd_add] : '0;
        if (rd_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (!bypass[i] && ((^rd_word[8*i +: 8]) != par_word[i])) begin
                    perr_now = 1'b1;
                end
            end
        end
    end
`else
    assign perr_now = 1'b0;
`endif

    always_comb begin
        s1_d       = '0;
        s1_d.data  = rd_ok ? rd_merged : '0;
        s1_d.valid = rd;
        s1_d.coll  = coll_now;
        s1_d.rerr  = rd_oor;
        s1_d.perr  = perr_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        rd_stage_t s2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_q <= '0;
            end else begin
                s2_q <= s1_q;
            end
        end

        assign res = s2_q;
    end else begin : g_lat1
        assign res = s1_q;
    end

    assign out        = res.data;
    assign rd_valid   = res.valid;
    assign collision  = res.coll;
    assign range_err  = res.rerr;
    assign parity_err = res.perr;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb/tb_dual_port_ram_be.sv - scoreboard bench for dual_port_ram_be (RD_LAT=1/RDW_MODE=0 and RD_LAT=2/RDW_MODE=1)
module tb_dual_port_ram_be;

`ifdef DUAL_PORT_RAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        coll;
        logic        rerr;
        logic        perr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [11:0] wr_add;
    logic [7:0]  wr_be;
    logic [63:0] in;
    logic        rd;
    logic [11:0] rd_add;

    logic [63:0] a_out, b_out;
    logic        a_valid, b_valid, a_coll, b_coll, a_rerr, b_rerr, a_perr, b_perr;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    dual_port_ram_be #(.DATA_W(64), .ADDR_W(12), .DEPTH(3000), .RD_LAT(1), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .in(in),
        .rd(rd), .rd_add(rd_add), .out(a_out), .rd_valid(a_valid), .collision(a_coll),
        .range_err(a_rerr), .parity_err(a_perr)
    );

    dual_port_ram_be #(.DATA_W(64), .ADDR_W(12), .DEPTH(3000), .RD_LAT(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wr_add(wr_add), .wr_be(wr_be), .in(in),
        .rd(rd), .rd_add(rd_add), .out(b_out), .rd_valid(b_valid), .collision(b_coll),
        .range_err(b_rerr), .parity_err(b_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0] ^ 8'hC3;
        return {8{b}};
    endfunction

    // ea_d/eb_d: expected data for dut_a (old-data mode) and dut_b (new-data mode)
    task automatic drive(input logic w, input logic [11:0] wa, input logic [7:0] be, input logic [63:0] d,
                         input logic r, input logic [11:0] ra, input logic [63:0] ea_d, input logic [63:0] eb_d,
                         input logic coll, input logic rerr, input logic perr);
        exp_t e;
        @(negedge clk);
        wr = w; wr_add = wa; wr_be = be; in = d;
        rd = r; rd_add = ra;
        if (r) begin
            e.coll = coll; e.rerr = rerr; e.perr = perr;
            e.cyc = cyc + 1; e.data = ea_d; qa.push_back(e);
            e.cyc = cyc + 2; e.data = eb_d; qb.push_back(e);
        end
    endtask

    task automatic wr_only(input logic [11:0] wa, input logic [7:0] be, input logic [63:0] d);
        drive(1'b1, wa, be, d, 1'b0, 12'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_only(input logic [11:0] ra, input logic [63:0] exp_d, input logic rerr);
        drive(1'b0, 12'd0, 8'h00, 64'd0, 1'b1, ra, exp_d, exp_d, 1'b0, rerr, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 12'd0, 8'h00, 64'd0, 1'b0, 12'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_unexpected_valid: got rd_valid=1 expected 0");
                end else begin
                    ea = qa.pop_front();
                    chk("a_latency", 64'(cyc), 64'(ea.cyc));
                    chk("a_out", a_out, ea.data);
                    chk("a_collision", 64'(a_coll), 64'(ea.coll));
                    chk("a_range_err", 64'(a_rerr), 64'(ea.rerr));
                    chk("a_parity_err", 64'(a_perr), 64'(ea.perr));
                end
            end else begin
                chk("a_idle_out", a_out, 64'd0);
                chk("a_idle_flags", 64'({a_coll, a_rerr, a_perr}), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_valid) begin
                if (qb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_unexpected_valid: got rd_valid=1 expected 0");
                end else begin
                    eb = qb.pop_front();
                    chk("b_latency", 64'(cyc), 64'(eb.cyc));
                    chk("b_out", b_out, eb.data);
                    chk("b_collision", 64'(b_coll), 64'(eb.coll));
                    chk("b_range_err", 64'(b_rerr), 64'(eb.rerr));
                    chk("b_parity_err", 64'(b_perr), 64'(eb.perr));
                end
            end else begin
                chk("b_idle_out", b_out, 64'd0);
                chk("b_idle_flags", 64'({b_coll, b_rerr, b_perr}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr = 1'b0; wr_add = '0; wr_be = '0; in = '0; rd = 1'b0; rd_add = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {a_out[62:0], a_valid}, 64'd0);
        chk("reset_outputs_b", {b_out[62:0], b_valid}, 64'd0);
        chk("reset_flags", 64'({a_coll, a_rerr, a_perr, b_coll, b_rerr, b_perr}), 64'd0);
        rst_n = 1'b1;

        // Full write then immediate read
        wr_only(12'd5, 8'hFF, 64'h0123_4567_89AB_CDEF);
        rd_only(12'd5, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Partial byte-enable write
        wr_only(12'd7, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_only(12'd7, 8'h0F, 64'h0);
        rd_only(12'd7, 64'hFFFF_FFFF_0000_0000, 1'b0);

        // Read-during-write collisions
        wr_only(12'd9, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        drive(1'b1, 12'd9, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 12'd9,
              64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 1'b0);
        rd_only(12'd9, 64'h5555_5555_5555_5555, 1'b0);
        drive(1'b1, 12'd9, 8'h00, 64'h1234_5678_9ABC_DEF0, 1'b1, 12'd9,
              64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 12'd9, 8'h01, 64'h0, 1'b1, 12'd9,
              64'h5555_5555_5555_5555, 64'h5555_5555_5555_5500, 1'b1, 1'b0, 1'b0);
        rd_only(12'd9, 64'h5555_5555_5555_5500, 1'b0);

        // Burst of reads with a single bubble at address 8
        for (int i = 0; i < 16; i++) wr_only(12'(i), 8'hFF, pat(i));
        for (int i = 0; i < 16; i++) begin
            if (i == 8) idle(1);
            rd_only(12'(i), pat(i), 1'b0);
        end
        idle(3);

        // Reset in the middle of a burst
        for (int i = 0; i < 6; i++) rd_only(12'(i), pat(i), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("midreset_a", {a_out[62:0], a_valid}, 64'd0);
        chk("midreset_b", {b_out[62:0], b_valid}, 64'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        rd_only(12'd3, pat(3), 1'b0);
        rd_only(12'd10, pat(10), 1'b0);
        idle(2);

        // Address range limits
        wr_only(12'd3500, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        rd_only(12'd3500, 64'd0, 1'b1);
        drive(1'b1, 12'd2999, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b1, 12'd3000, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 12'd3500, 8'hFF, 64'h1111_2222_3333_4444, 1'b1, 12'd3500, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        rd_only(12'd2999, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

        // Parity: corrupt bit 17 (byte 2) when parity storage exists
        wr_only(12'd3, 8'hFF, 64'h1122_3344_5566_7788);
        idle(1);
`ifdef DUAL_PORT_RAM_PARITY_EN
        dut_a.mem[3][17] = ~dut_a.mem[3][17];
        dut_b.mem[3][17] = ~dut_b.mem[3][17];
        drive(1'b0, 12'd0, 8'h00, 64'd0, 1'b1, 12'd3,
              64'h1122_3344_5564_7788, 64'h1122_3344_5564_7788, 1'b0, 1'b0, PAR);
`else
        drive(1'b0, 12'd0, 8'h00, 64'd0, 1'b1, 12'd3,
              64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0, 1'b0, PAR);
`endif

        idle(4);
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
